mdu_iterative: RTL and testbench

//  Iterative RV32M/RV64M multiply/divide unit; executes all 8 M-extension funct3 ops
//  (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at one result bit per cycle.

---
 rtl/mdu_iterative_if.sv | 27 ++
 rtl/mdu_iterative.sv | 179 +++++++++++++++++
 tb/tb_mdu_iterative.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iterative_if.sv
// Request/response handshake bundle for the iterative multiply/divide unit.
// The master drives requests and consumes results; the slave is the unit.
interface mdu_iterative_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one result bit per cycle, fixed latency for every op.
module mdu_iterative #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    mdu_iterative_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(XLEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE      = XLEN'(1);

    // Control state (reset)
    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic             valid_q;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] result_tag;

    // Datapath state (loaded on acceptance)
    logic [2:0]        funct3;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              sign_a;
    logic              sign_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN:0]     rem;

    logic accept;
    assign accept        = (state == S_IDLE) && bus.in_valid && !flush;
    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = valid_q;
    assign bus.out_result = result;
    assign bus.out_tag    = result_tag;

    // Request decode: MULHU/DIVU/REMU fully unsigned, MULHSU has unsigned B.
    logic            req_signed_a;
    logic            req_signed_b;
    logic            req_sign_a;
    logic            req_sign_b;
    logic [XLEN-1:0] req_mag_a;
    logic [XLEN-1:0] req_mag_b;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req_signed_a = 1'b0;
        req_signed_b = 1'b0;
        case (bus.in_funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                req_signed_a = 1'b1;
                req_signed_b = 1'b1;
            end
            3'd2:    req_signed_a = 1'b1;
            default: ;
        endcase
        req_sign_a = req_signed_a & bus.in_rs1[XLEN-1];
        req_sign_b = req_signed_b & bus.in_rs2[XLEN-1];
        req_mag_a  = req_sign_a ? -bus.in_rs1 : bus.in_rs1;
        req_mag_b  = req_sign_b ? -bus.in_rs2 : bus.in_rs2;
    end

    // One iteration of each algorithm; only the one matching funct3 is used in FIX.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;

    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : '0);
        prod_next = {mul_sum, prod[XLEN-1:1]};
        div_shift = {rem[XLEN-1:0], quo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ge    = !div_diff[XLEN];
    end

    // Sign correction and special-case forcing
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_signed;
    logic [XLEN-1:0]   rem_signed;
    logic [XLEN-1:0]   a_value;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        prod_signed = (sign_a ^ sign_b) ? -prod : prod;
        quo_signed  = (sign_a ^ sign_b) ? -quo : quo;
        rem_signed  = sign_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        a_value     = sign_a ? -mag_a : mag_a;
        div_zero    = (mag_b == '0);
        div_ovf     = sign_a && sign_b && (mag_a == MOST_NEG) && (mag_b == ONE);
        if (div_zero) begin
            quo_signed = '1;
            rem_signed = a_value;
        end else if (div_ovf) begin
            quo_signed = MOST_NEG;
            rem_signed = '0;
        end
        if (!funct3[2])
            fix_result = (funct3[1:0] == 2'd0) ? prod_signed[XLEN-1:0]
                                               : prod_signed[2*XLEN-1:XLEN];
        else
            fix_result = funct3[1] ? rem_signed : quo_signed;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            valid_q    <= 1'b0;
            result     <= '0;
            result_tag <= '0;
        end else if (flush) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_CALC;
                        count <= COUNT_LOAD;
                    end
                end
                S_CALC: begin
                    count <= count - 1'b1;
                    if (count == '0)
                        state <= S_FIX;
                end
                S_FIX: begin
                    result     <= fix_result;
                    result_tag <= tag;
                    state      <= S_DONE;
                end
                default: begin
                    // out_valid is registered: it rises one cycle after entering DONE.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: operand/iteration registers are not reset; they are always reloaded on acceptance
    // before being read, so a reset would only add fan-out on rst.
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3 <= bus.in_funct3;
            tag    <= bus.in_tag;
            mag_a  <= req_mag_a;
            mag_b  <= req_mag_b;
            sign_a <= req_sign_a;
            sign_b <= req_sign_b;
            prod   <= {{XLEN{1'b0}}, req_mag_b};
            quo    <= req_mag_a;
            rem    <= '0;
        end else if (state == S_CALC) begin
            prod <= prod_next;
            quo  <= {quo[XLEN-2:0], div_ge};
            rem  <= div_ge ? div_diff : div_shift;
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative at XLEN=32: arithmetic results,
// special divides, latency, backpressure, flush and reset.
module tb_mdu_iterative;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int LAT   = XLEN + 2;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mdu_iterative_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    mdu_iterative #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] t);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_funct3 = f;
        bus.in_rs1    = a;
        bus.in_rs2    = b;
        bus.in_tag    = t;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid, counting edges since acceptance, then consumes the result.
    task automatic finish_op(output logic [31:0] res, output logic [4:0] rtag,
                             output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        res = '0;
        rtag = '0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            res  = bus.out_result;
            rtag = bus.out_tag;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, output logic [31:0] res,
                          output logic [4:0] rtag, output int lat, output bit ok);
        start_op(f, a, b, t);
        finish_op(res, rtag, lat, ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_result !== 32'h0 || bus.out_tag !== 5'h0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b result=%h tag=%h, want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_result, bus.out_tag);
        end
        #1 rst = 1'b0;
    endtask

    task automatic run_table(input string name, input vec_t v[], input int first_tag);
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        bit          ok;
        for (int i = 0; i < v.size(); i++) begin
            run_op(v[i].f, v[i].a, v[i].b, 5'(first_tag + i), res, rtag, lat, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s[%0d] timeout: out_valid never rose", name, i);
                continue;
            end
            if (res !== v[i].exp || rtag !== 5'(first_tag + i)) begin
                errors++;
                $display("FAIL %s[%0d] f=%0d a=%h b=%h: got %h tag %0d, want %h tag %0d",
                         name, i, v[i].f, v[i].a, v[i].b, res, rtag, v[i].exp, first_tag + i);
            end
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL %s[%0d] latency: got %0d, want %0d", name, i, lat, LAT);
            end
        end
    endtask

    task automatic test_mul();
        vec_t v[];
        v = new[5];
        v[0] = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        v[1] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[2] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        v[3] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[4] = '{3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF};
        run_table("mul", v, 1);
    endtask

    task automatic test_div();
        vec_t v[];
        v = new[6];
        v[0] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        v[1] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        v[2] = '{3'd5, 32'd100,       32'd7,         32'd14};
        v[3] = '{3'd7, 32'd100,       32'd7,         32'd2};
        v[4] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        v[5] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
        run_table("div", v, 8);
    endtask

    task automatic test_div_special();
        vec_t v[];
        v = new[6];
        v[0] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
        v[1] = '{3'd7, 32'd5,         32'd0,         32'd5};
        v[2] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[3] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        v[4] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
        v[5] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
        run_table("divspec", v, 20);
    endtask

    task automatic test_backpressure();
        bit ok;
        start_op(3'd5, 32'd100, 32'd7, 5'd17);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL backpressure timeout: out_valid never rose");
            return;
        end
        bus.in_valid  = 1'b1;
        bus.in_funct3 = 3'd0;
        bus.in_rs1    = 32'd2;
        bus.in_rs2    = 32'd2;
        bus.in_tag    = 5'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd14 ||
                bus.out_tag !== 5'd17 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b result=%h tag=%0d in_ready=%b, want 1 0000000e 17 0",
                         i, bus.out_valid, bus.out_result, bus.out_tag, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL consume: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_flush_rst();
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        bit          ok;
        bit          seen;

        start_op(3'd0, 32'd5, 32'd5, 5'd1);
        repeat (5) @(posedge clk);
        #1;
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_funct3 = 3'd0;
        bus.in_rs1    = 32'd1;
        bus.in_rs2    = 32'd1;
        bus.in_tag    = 5'd2;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_quiet: out_valid rose after flush, want 0");
        end

        start_op(3'd0, 32'd6, 32'd6, 5'd4);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.out_result !== 32'h0 || bus.out_tag !== 5'h0) begin
            errors++;
            $display("FAIL midrst: valid=%b in_ready=%b result=%h tag=%0d, want 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.out_result, bus.out_tag);
        end

        run_op(3'd0, 32'd3, 32'd4, 5'd9, res, rtag, lat, ok);
        checks++;
        if (!ok || res !== 32'd12 || rtag !== 5'd9) begin
            errors++;
            $display("FAIL after_rst ok=%b: got %h tag %0d, want 0000000c tag 9", ok, res, rtag);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        bit          ok;
        // Second op issued on the negedge straight after the first is consumed.
        run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 5'd30, res, rtag, lat, ok);
        checks++;
        if (!ok || res !== 32'h0000_0001 || rtag !== 5'd30) begin
            errors++;
            $display("FAIL b2b[0] ok=%b: got %h tag %0d, want 00000001 tag 30", ok, res, rtag);
        end
        run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 5'd31, res, rtag, lat, ok);
        checks++;
        if (!ok || res !== 32'h0000_0000 || rtag !== 5'd31 || lat != LAT) begin
            errors++;
            $display("FAIL b2b[1] ok=%b: got %h tag %0d lat %0d, want 00000000 tag 31 lat %0d",
                     ok, res, rtag, lat, LAT);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_funct3 = 3'd0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_backpressure();
        test_flush_rst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
